// File: rtl/overcurrent_trip_unit_pkg.sv
// Shared encodings for the overcurrent trip unit: FSM states, trip causes,
// accumulator width and the accumulator operation codes.
package overcurrent_pkg;

    localparam int ACC_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PICKUP  = 2'd1,
        ST_DECAY   = 2'd2,
        ST_TRIPPED = 2'd3
    } trip_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'b00,
        CAUSE_TIMED = 2'b01,
        CAUSE_INST  = 2'b10
    } trip_cause_e;

    typedef enum logic [2:0] {
        ACC_HOLD  = 3'd0,
        ACC_CLEAR = 3'd1,
        ACC_LOAD  = 3'd2,
        ACC_ADD   = 3'd3,
        ACC_SUB   = 3'd4
    } acc_op_e;

endpackage

// File: rtl/overcurrent_trip_unit_if.sv
// Measurement/command bundle between the RMS front end, the operator panel
// and the trip unit.
interface overcurrent_trip_unit_if;

    logic [15:0]                       I_rms;
    logic                              trip_reset;
    logic                              trip;
    logic                              pickup;
    logic [1:0]                        trip_cause;
    logic [overcurrent_pkg::ACC_W-1:0] timer_acc;

    modport master (
        output I_rms,
        output trip_reset,
        input  trip,
        input  pickup,
        input  trip_cause,
        input  timer_acc
    );

    modport slave (
        input  I_rms,
        input  trip_reset,
        output trip,
        output pickup,
        output trip_cause,
        output timer_acc
    );

endinterface

// File: rtl/overcurrent_trip_unit_sat_accumulator.sv
// Inverse-time accumulator: saturating add/subtract, load and clear.
// acc_d exposes the value that will be registered on the next edge.
module sat_accumulator
    import overcurrent_pkg::*;
(
    input  logic             clk_800hz,
    input  logic             reset,
    input  acc_op_e          op,
    input  logic [ACC_W-1:0] operand,
    output logic [ACC_W-1:0] acc_d,
    output logic [ACC_W-1:0] acc_q
);

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        logic [ACC_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    endfunction

    function automatic logic [ACC_W-1:0] sat_sub(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

    always_comb begin
        acc_d = acc_q;
        case (op)
            ACC_CLEAR: acc_d = '0;
            ACC_LOAD:  acc_d = operand;
            ACC_ADD:   acc_d = sat_add(acc_q, operand);
            ACC_SUB:   acc_d = sat_sub(acc_q, operand);
            default:   acc_d = acc_q;
        endcase
    end

    always_ff @(posedge clk_800hz or posedge reset) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

endmodule

// File: rtl/overcurrent_trip_unit.sv
// Overcurrent relay: instantaneous element plus an inverse-time element with
// pickup/dropout hysteresis, reset decay and a latched, acknowledged trip.
module overcurrent_trip_unit
    import overcurrent_pkg::*;
#(
    parameter logic [15:0]      PICKUP_LEVEL  = 16'd1600,
    parameter logic [15:0]      DROPOUT_LEVEL = 16'd1536,
    parameter logic [15:0]      INST_LEVEL    = 16'd4000,
    parameter logic [ACC_W-1:0] TRIP_ACC      = 24'd160000,
    parameter logic [ACC_W-1:0] DECAY_STEP    = 24'd800
) (
    input  logic                     clk_800hz,
    input  logic                     reset,
    overcurrent_trip_unit_if.slave   ocp
);

    if (DROPOUT_LEVEL >= PICKUP_LEVEL) begin : g_bad_levels
        $error("DROPOUT_LEVEL must be below PICKUP_LEVEL");
    end

    trip_state_e      state_q, state_d;
    trip_cause_e      cause_q, cause_d;
    logic             trip_q, trip_d;
    logic             pickup_q;
    acc_op_e          acc_op;
    logic [ACC_W-1:0] acc_operand;
    logic [ACC_W-1:0] acc_d, acc_q;

    logic [15:0]      diff;
    logic [ACC_W-1:0] diff_ext;
    logic             over_inst, over_pu, below_do;

    // Difference only meaningful when over_pu; wraps otherwise and is unused.
    assign diff      = ocp.I_rms - PICKUP_LEVEL;
    assign diff_ext  = {{(ACC_W-16){1'b0}}, diff};
    assign over_inst = (ocp.I_rms >= INST_LEVEL);
    assign over_pu   = (ocp.I_rms >  PICKUP_LEVEL);
    assign below_do  = (ocp.I_rms <= DROPOUT_LEVEL);

    always_comb begin
        acc_op      = ACC_HOLD;
        acc_operand = diff_ext;
        case (state_q)
            ST_IDLE:    acc_op = (!over_inst && over_pu) ? ACC_LOAD : ACC_CLEAR;
            ST_PICKUP:  if (!over_inst && over_pu) acc_op = ACC_ADD;
            ST_DECAY: begin
                if (!over_inst) begin
                    if (over_pu) begin
                        acc_op = ACC_ADD;
                    end else begin
                        acc_op      = ACC_SUB;
                        acc_operand = DECAY_STEP;
                    end
                end
            end
            ST_TRIPPED: if (ocp.trip_reset && below_do) acc_op = ACC_CLEAR;
            default:    acc_op = ACC_HOLD;
        endcase
    end

    sat_accumulator u_acc (
        .clk_800hz (clk_800hz),
        .reset     (reset),
        .op        (acc_op),
        .operand   (acc_operand),
        .acc_d     (acc_d),
        .acc_q     (acc_q)
    );

    // Trip decisions look at the accumulator value being written this edge.
    always_comb begin
        state_d = state_q;
        trip_d  = trip_q;
        cause_d = cause_q;
        if (state_q != ST_TRIPPED && over_inst) begin
            state_d = ST_TRIPPED;
            trip_d  = 1'b1;
            cause_d = CAUSE_INST;
        end else begin
            case (state_q)
                ST_IDLE:   if (over_pu) state_d = ST_PICKUP;
                ST_PICKUP, ST_DECAY: begin
                    if (over_pu) begin
                        state_d = ST_PICKUP;
                        if (acc_d >= TRIP_ACC) begin
                            state_d = ST_TRIPPED;
                            trip_d  = 1'b1;
                            cause_d = CAUSE_TIMED;
                        end
                    end else if (state_q == ST_PICKUP) begin
                        if (below_do) state_d = ST_DECAY;
                    end else if (acc_d == '0) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_TRIPPED: begin
                    if (ocp.trip_reset && below_do) begin
                        state_d = ST_IDLE;
                        trip_d  = 1'b0;
                        cause_d = CAUSE_NONE;
                    end
                end
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_800hz or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            trip_q   <= 1'b0;
            cause_q  <= CAUSE_NONE;
            pickup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            trip_q   <= trip_d;
            cause_q  <= cause_d;
            pickup_q <= (state_d == ST_PICKUP);
        end
    end

    assign ocp.trip       = trip_q;
    assign ocp.pickup     = pickup_q;
    assign ocp.trip_cause = cause_q;
    assign ocp.timer_acc  = acc_q;

endmodule

// File: doc/overcurrent_trip_unit.md
OVERCURRENT_TRIP_UNIT -- requirements
Module: overcurrent_trip_unit

Interface
REQ-001 Parameter PICKUP_LEVEL, default 16'd1600, is the timed-element pickup threshold in I_rms counts.
REQ-002 Parameter DROPOUT_LEVEL, default 16'd1536, is the reset threshold; it SHALL satisfy DROPOUT_LEVEL < PICKUP_LEVEL.
REQ-003 Parameter INST_LEVEL, default 16'd4000, is the instantaneous-element threshold.
REQ-004 Parameter TRIP_ACC, default 24'd160000, is the inverse-time accumulator trip threshold.
REQ-005 Parameter DECAY_STEP, default 24'd800, is the accumulator decrement per sample during reset decay.
REQ-006 clk_800hz  in  1  sample clock; one I_rms evaluation per rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 I_rms  in  16  unsigned RMS magnitude from rms_estimation_module.
REQ-009 trip_reset  in  1  operator trip acknowledge, level-sampled.
REQ-010 trip  out  1  registered trip command, latched.
REQ-011 pickup  out  1  high while state is PICKUP.
REQ-012 trip_cause  out  2  00 none, 01 timed, 10 instantaneous; 11 is never driven.
REQ-013 timer_acc  out  24  current accumulator value, for observation.

Function
REQ-014 The FSM SHALL have four states: IDLE=0, PICKUP=1, DECAY=2, TRIPPED=3, and SHALL evaluate I_rms once per clk_800hz edge.
REQ-015 In any non-TRIPPED state, I_rms >= INST_LEVEL SHALL move the FSM to TRIPPED with trip_cause=10, taking priority over all other conditions.
REQ-016 In IDLE, I_rms > PICKUP_LEVEL SHALL move the FSM to PICKUP and load acc = I_rms - PICKUP_LEVEL; otherwise acc holds at 0.
REQ-017 In PICKUP with I_rms > PICKUP_LEVEL, acc SHALL become acc + (I_rms - PICKUP_LEVEL), saturating at 24'hFFFFFF.
REQ-018 In PICKUP, if the new acc >= TRIP_ACC, the FSM SHALL move to TRIPPED on the same edge with trip_cause=01.
REQ-019 In PICKUP with DROPOUT_LEVEL < I_rms <= PICKUP_LEVEL, acc and state SHALL hold (hysteresis band).
REQ-020 In PICKUP with I_rms <= DROPOUT_LEVEL, the FSM SHALL move to DECAY and acc SHALL hold.
REQ-021 In DECAY with I_rms > PICKUP_LEVEL, the FSM SHALL return to PICKUP and accumulate per REQ-017 on that edge.
REQ-022 In DECAY otherwise, acc SHALL become acc - DECAY_STEP, saturating at 0; the FSM SHALL enter IDLE on the edge where the result is 0.
REQ-023 In TRIPPED, trip, trip_cause and acc SHALL hold.
REQ-024 TRIPPED SHALL exit to IDLE only on an edge where trip_reset=1 and I_rms <= DROPOUT_LEVEL; that edge SHALL clear trip, trip_cause and acc.
REQ-025 trip_reset SHALL be ignored in every other state and in TRIPPED while I_rms > DROPOUT_LEVEL.
REQ-026 All outputs SHALL be registered; trip SHALL assert on the clk_800hz edge that samples the trip condition (latency of 1 edge).
REQ-027 The difference term SHALL be computed as 16-bit unsigned and zero-extended to 24 bits before addition.

Reset
REQ-028 While reset=1, the block SHALL force state=IDLE, acc=0, trip=0, pickup=0 and trip_cause=00 immediately, independent of clk_800hz.
REQ-029 Deasserting reset mid-timing SHALL restart timing from acc=0, with no memory of the previous accumulation.

Structure
REQ-030 Package overcurrent_pkg SHALL hold the state encoding, the trip_cause codes and ACC_W=24.
REQ-031 One sub-module, sat_accumulator, SHALL implement saturating add/subtract/load/clear of the 24-bit accumulator.

Verification
REQ-032 Constant I_rms=1414 for 1000 samples -> pickup=0, trip=0, timer_acc=0 throughout.
REQ-033 Step I_rms 0->2000 -> pickup=1 after the first edge; trip=1 and trip_cause=01 after exactly the 400th sample (acc=160000).
REQ-034 Step I_rms 0->4500 -> trip=1 and trip_cause=10 after the first edge; timer_acc=0.
REQ-035 2000 for 200 samples (acc=80000), then 1000 -> DECAY; IDLE with acc=0 after 100 further samples; no trip.
REQ-036 After a timed trip: trip_reset=1 with I_rms=2000 -> trip stays 1; I_rms=1000 with trip_reset=1 -> IDLE and trip=0 on the next edge.
REQ-037 Assert reset between clock edges at acc=50000 -> all outputs 0 before the next edge; the rerun from 2000 trips 400 samples after deassertion.
